alu_mem_block: RTL and testbench
================================

ALU_MEM_BLOCK -- requirements
Module: alu_mem_block

Interface
Parameters:
REQ-001 DEPTH, default 64, number of 32-bit words in the data memory (power of two).

Ports:
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 alu_op  input  2  operation class: 00 load/store, 01 branch, 10 register/immediate ALU, 11 reserved.
REQ-005 funct3  input  3  instruction funct3 field.
REQ-006 op5  input  1  opcode bit 5 (1 = register-register form).
REQ-007 funct7_5  input  1  instruction bit 30.
REQ-008 src_a  input  32  ALU operand A.
REQ-009 src_b  input  32  ALU operand B.
REQ-010 alu_control  output  3  decoded ALU operation code.
REQ-011 alu_result  output  32  ALU result.
REQ-012 zero_flag  output  1  high when alu_result == 0.
REQ-013 write_enable  input  1  data memory write strobe.
REQ-014 adr  input  32  data memory byte address.
REQ-015 din  input  32  data memory write data.
REQ-016 dout  output  32  data memory read data.

Function
REQ-017 The ALU control encodings SHALL be: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-018 The decoder SHALL map alu_op: 00 -> 000; 01 -> 001; 11 -> 000.
REQ-019 For alu_op=10, funct3=000 SHALL give 001 when op5 and funct7_5 are both 1, else 000.
REQ-020 For alu_op=10, the mapping SHALL be: funct3 010 -> 101, 110 -> 011, 111 -> 010; every other funct3 -> 000.
REQ-021 The decoder SHALL be purely combinational; the ALU SHALL execute the decoded alu_control.
REQ-022 add/sub SHALL be 32-bit modulo 2^32 with carry/overflow discarded.
REQ-023 slt SHALL compare src_a < src_b as signed two's complement and produce 32'd1 or 32'd0.
REQ-024 ALU control codes 100, 110 and 111 SHALL produce alu_result = 0.
REQ-025 alu_result and zero_flag SHALL be combinational, with zero latency from the inputs.
REQ-026 The memory word index SHALL be adr[log2(DEPTH)+1:2]; adr[1:0] and higher bits SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-027 dout SHALL be a combinational read of the addressed word.
REQ-028 When write_enable=1, din SHALL be written to the addressed word on the rising edge of clk.
REQ-029 A read of the address being written SHALL return the old data until the edge, and the new data after it.
REQ-030 When write_enable=0, memory contents SHALL be unchanged.

Reset
REQ-031 Asserting reset SHALL immediately clear every memory word to 0, so dout=0, without waiting for clk.
REQ-032 While reset is high, writes SHALL be blocked.
REQ-033 A reset asserted in the same cycle as a write SHALL take priority over the write.
REQ-034 The decoder and ALU hold no state; their outputs follow the inputs during reset.

Structure
REQ-035 A shared package SHALL hold the ALU control encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT), the alu_op encodings, and the default DEPTH.
REQ-036 The block SHALL be split into sub-modules alu_decoder, alu and data_memory, instantiated inside alu_mem_block.
REQ-037 The block SHALL contain no other state.

Verification
REQ-038 alu_op=10, funct3=000, op5=1, funct7_5=1, src_a=7, src_b=7 -> alu_control=001, alu_result=0, zero_flag=1.
REQ-039 alu_op=10, funct3=000, op5=0, funct7_5=1 (addi form), src_a=32'hFFFFFFFF, src_b=1 -> alu_control=000, alu_result=0, zero_flag=1.
REQ-040 alu_op=10, funct3=010, src_a=32'hFFFFFFFE (-2), src_b=3 -> alu_result=1; with the operands swapped -> alu_result=0.
REQ-041 alu_op=10, funct3=110 then 111, src_a=32'hF0F0, src_b=32'h0FF0 -> 32'hFFF0 then 32'h00F0; alu_op=01 -> control 001.
REQ-042 Write din=32'hDEADBEEF to adr=8 with write_enable=1 -> dout at adr=8 (and adr=10, and adr=8+DEPTH*4) reads 32'hDEADBEEF after the edge, and 0 before it.
REQ-043 After the write in REQ-042, pulse reset asynchronously between clock edges -> dout=0 immediately.
REQ-044 Assert write_enable during reset -> memory stays 0.

Source files
------------

// File: rtl/alu_mem_block_pkg.sv
// Shared encodings for the ALU decoder, ALU and data memory.
// Every sub-module of alu_mem_block imports this package.
package alu_mem_block_pkg;

  localparam int DEFAULT_DEPTH = 64;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ALUOP_LDST   = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_ARITH  = 2'b10,
    ALUOP_RSVD   = 2'b11
  } alu_op_e;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/alu_mem_block_if.sv
// Bundle of ALU and data memory signals.
// The master drives the instruction fields, operands and memory requests; the slave returns the results.
interface alu_mem_block_if;

  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        op5;
  logic        funct7_5;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;
  logic        zero_flag;
  logic        write_enable;
  logic [31:0] adr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (
    output alu_op, funct3, op5, funct7_5, src_a, src_b, write_enable, adr, din,
    input  alu_control, alu_result, zero_flag, dout
  );

  modport slave (
    input  alu_op, funct3, op5, funct7_5, src_a, src_b, write_enable, adr, din,
    output alu_control, alu_result, zero_flag, dout
  );

endinterface

// File: rtl/alu_mem_block_alu.sv
// Combinational 32-bit ALU.
// It supports add, sub, and, or and signed set-less-than.
module alu
  import alu_mem_block_pkg::*;
(
  input  logic [2:0]  alu_control,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] alu_result,
  output logic        zero_flag
);

  always_comb begin
    alu_result = '0;
    case (alu_control)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {31'b0, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  assign zero_flag = (alu_result == 32'd0);

endmodule

// File: rtl/alu_mem_block_data_memory.sv
// Word-addressed data memory with a combinational read port and a synchronous write port.
// An asynchronous reset clears every word.
module data_memory
  import alu_mem_block_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [31:0] adr,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] idx;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic          unused_adr_bits;

  // Byte-offset and high address bits are dropped, so addresses alias modulo DEPTH*4.
  assign idx             = adr[AW+1:2];
  assign unused_adr_bits = ^{adr[31:AW+2], adr[1:0]};

  always_comb begin
    mem_d = mem_q;
    if (write_enable) begin
      mem_d[idx] = din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign dout = mem_q[idx];

endmodule

// File: rtl/alu_mem_block_decoder.sv
// Combinational ALU control decoder.
// It maps alu_op and the funct fields to a 3-bit ALU operation code.
module alu_decoder
  import alu_mem_block_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  // Subtraction applies only to the register-register form; addi keeps bit 30 as immediate data.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_BRANCH: alu_control = ALU_SUB;
      ALUOP_ARITH: begin
        case (funct3)
          F3_ADD:  alu_control = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
          F3_SLT:  alu_control = ALU_SLT;
          F3_OR:   alu_control = ALU_OR;
          F3_AND:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_mem_block.sv
// Top level: the ALU decoder drives the ALU, with an independent data memory alongside.
// Only the data memory holds state.
module alu_mem_block
  import alu_mem_block_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  alu_mem_block_if.slave bus
);

  logic [2:0]  alu_control;
  logic [31:0] alu_result;
  logic        zero_flag;
  logic [31:0] dout;

  alu_decoder u_decoder (
    .alu_op      (bus.alu_op),
    .funct3      (bus.funct3),
    .op5         (bus.op5),
    .funct7_5    (bus.funct7_5),
    .alu_control (alu_control)
  );

  alu u_alu (
    .alu_control (alu_control),
    .src_a       (bus.src_a),
    .src_b       (bus.src_b),
    .alu_result  (alu_result),
    .zero_flag   (zero_flag)
  );

  data_memory #(.DEPTH(DEPTH)) u_mem (
    .clk          (clk),
    .reset        (reset),
    .write_enable (bus.write_enable),
    .adr          (bus.adr),
    .din          (bus.din),
    .dout         (dout)
  );

  assign bus.alu_control = alu_control;
  assign bus.alu_result  = alu_result;
  assign bus.zero_flag   = zero_flag;
  assign bus.dout        = dout;

endmodule

// File: tb/tb_alu_mem_block.sv
// Self-checking bench for alu_mem_block.
// Directed vectors plus randomized ALU and memory traffic, compared against a behavioural model.
module tb_alu_mem_block;
  import alu_mem_block_pkg::*;

  localparam int DEPTH = DEFAULT_DEPTH;

  logic clk = 1'b0;
  logic reset;
  int   check_count = 0;
  int   pass_count  = 0;
  logic [31:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  alu_mem_block_if bus ();

  alu_mem_block #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Count one comparison and report it if the observed value differs from the expected one.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Reference decoder: the operation named by each instruction class.
  function automatic logic [2:0] model_control(input logic [1:0] op, input logic [2:0] f3,
                                               input logic o5, input logic f7);
    if (op == 2'b01) return 3'b001;
    if (op != 2'b10) return 3'b000;
    if (f3 == 3'b000) return (o5 && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic [31:0] model_result(input logic [2:0] ctrl, input logic [31:0] a,
                                               input logic [31:0] b);
    longint unsigned sum;
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    case (ctrl)
      3'b000: begin sum = longint'(a) + longint'(b); return sum[31:0]; end
      3'b001: begin sum = longint'(a) + 64'h1_0000_0000 - longint'(b); return sum[31:0]; end
      3'b010: return a & b;
      3'b011: return a | b;
      3'b101: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int mem_index(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3, input logic o5,
                               input logic f7, input logic [31:0] a, input logic [31:0] b);
    bus.alu_op   = op;
    bus.funct3   = f3;
    bus.op5      = o5;
    bus.funct7_5 = f7;
    bus.src_a    = a;
    bus.src_b    = b;
    #1;
  endtask

  task automatic checkAlu(input string tag);
    logic [2:0]  ctrl;
    logic [31:0] res;
    ctrl = model_control(bus.alu_op, bus.funct3, bus.op5, bus.funct7_5);
    res  = model_result(ctrl, bus.src_a, bus.src_b);
    checkOutput({tag, "_ctrl"}, {29'b0, bus.alu_control}, {29'b0, ctrl});
    checkOutput({tag, "_res"}, bus.alu_result, res);
    checkOutput({tag, "_zero"}, {31'b0, bus.zero_flag}, {31'b0, (res == 32'd0)});
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rd_adr;

    reset            = 1'b1;
    bus.write_enable = 1'b0;
    bus.adr          = 32'd0;
    bus.din          = 32'd0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    applyStimulus(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
    #11;
    checkOutput("reset_dout0", bus.dout, 32'd0);
    bus.adr = 32'd100;
    #1;
    checkOutput("reset_dout100", bus.dout, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed ALU vectors
    applyStimulus(2'b10, 3'b000, 1'b1, 1'b1, 32'd7, 32'd7);
    checkOutput("sub_ctrl", {29'b0, bus.alu_control}, 32'd1);
    checkOutput("sub_res", bus.alu_result, 32'd0);
    checkOutput("sub_zero", {31'b0, bus.zero_flag}, 32'd1);
    applyStimulus(2'b10, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1);
    checkOutput("addi_ctrl", {29'b0, bus.alu_control}, 32'd0);
    checkOutput("addi_res", bus.alu_result, 32'd0);
    checkOutput("addi_zero", {31'b0, bus.zero_flag}, 32'd1);
    applyStimulus(2'b10, 3'b010, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3);
    checkOutput("slt_neg", bus.alu_result, 32'd1);
    checkOutput("slt_zero_flag", {31'b0, bus.zero_flag}, 32'd0);
    applyStimulus(2'b10, 3'b010, 1'b1, 1'b0, 32'd3, 32'hFFFF_FFFE);
    checkOutput("slt_swap", bus.alu_result, 32'd0);
    applyStimulus(2'b10, 3'b110, 1'b1, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0);
    checkOutput("or_res", bus.alu_result, 32'h0000_FFF0);
    applyStimulus(2'b10, 3'b111, 1'b1, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0);
    checkOutput("and_res", bus.alu_result, 32'h0000_00F0);
    applyStimulus(2'b01, 3'b111, 1'b0, 1'b0, 32'd5, 32'd9);
    checkOutput("branch_ctrl", {29'b0, bus.alu_control}, 32'd1);
    checkOutput("branch_res", bus.alu_result, 32'hFFFF_FFFC);
    applyStimulus(2'b11, 3'b010, 1'b1, 1'b1, 32'd5, 32'd9);
    checkOutput("rsvd_ctrl", {29'b0, bus.alu_control}, 32'd0);

    // Randomized ALU traffic
    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      if ($urandom_range(0, 5) == 0) b = -a;
      applyStimulus(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b);
      checkAlu("rand_alu");
    end

    // Directed write, aliasing reads and async reset
    @(negedge clk);
    bus.adr          = 32'd8;
    bus.din          = 32'hDEAD_BEEF;
    bus.write_enable = 1'b1;
    #1;
    checkOutput("wr_before_edge", bus.dout, 32'd0);
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    checkOutput("wr_after_edge", bus.dout, 32'hDEAD_BEEF);
    bus.adr = 32'd10;
    #1;
    checkOutput("wr_alias_10", bus.dout, 32'hDEAD_BEEF);
    bus.adr = 32'd8 + DEPTH * 4;
    #1;
    checkOutput("wr_alias_wrap", bus.dout, 32'hDEAD_BEEF);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", bus.dout, 32'd0);
    bus.adr          = 32'd8;
    bus.din          = 32'h1234_5678;
    bus.write_enable = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("wr_during_reset", bus.dout, 32'd0);
    @(negedge clk);
    bus.write_enable = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("after_reset_release", bus.dout, 32'd0);

    // Randomized memory traffic; word index is narrowed to force frequent reuse
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      bus.write_enable = 1'($urandom_range(0, 1));
      bus.adr          = {$urandom_range(0, 255), 8'h00} ^ 32'($urandom_range(0, 63));
      bus.din          = $urandom;
      #1;
      checkOutput("mem_pre_edge", bus.dout, ref_mem[mem_index(bus.adr)]);
      @(posedge clk);
      if (bus.write_enable) ref_mem[mem_index(bus.adr)] = bus.din;
      #1;
      checkOutput("mem_post_edge", bus.dout, ref_mem[mem_index(bus.adr)]);
      bus.write_enable = 1'b0;
      rd_adr  = $urandom;
      bus.adr = rd_adr;
      #1;
      checkOutput("mem_read", bus.dout, ref_mem[mem_index(rd_adr)]);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
